// File: rtl/obu_parser_pkg.sv
// Shared parser/writer constants, OBU type codes and the OBU header field bundle.
package obu_parser_pkg;

  localparam int PARSER_DATA_WIDTH = 32;
  localparam int LEB128_MAX_BYTES  = 8;
  localparam int OBU_HDR_MAX_BYTES = 10;

  typedef enum logic [3:0] {
    SEQUENCE_HEADER    = 4'd1,
    TEMPORAL_DELIMITER = 4'd2,
    FRAME_HEADER       = 4'd3,
    TILE_GROUP         = 4'd4,
    METADATA           = 4'd5,
    FRAME              = 4'd6,
    PADDING            = 4'd15
  } obu_type_e;

  typedef struct packed {
    logic [3:0]  obu_type;
    logic        ext_flag;
    logic [2:0]  temporal_id;
    logic [1:0]  spatial_id;
    logic [55:0] obu_size;
  } obu_hdr_fields_t;

  // has_size_field is always set: the writer always appends obu_size.
  function automatic logic [7:0] obu_hdr_byte0(input obu_hdr_fields_t f);
    return {1'b0, f.obu_type, f.ext_flag, 1'b1, 1'b0};
  endfunction

  function automatic logic [7:0] obu_ext_byte(input obu_hdr_fields_t f);
    return {f.temporal_id, f.spatial_id, 3'b000};
  endfunction

endpackage

// File: rtl/obu_header_writer_if.sv
// Output word stream of the OBU header writer (valid/ready, MSB-first bytes).
interface obu_header_writer_if #(
  parameter int OUT_WIDTH = 32
) ();
  logic [OUT_WIDTH-1:0]         data_out;
  logic                         valid;
  logic                         ready;
  logic                         last;
  logic                         pad;
  logic [$clog2(OUT_WIDTH)-1:0] pad_len;

  modport master (output data_out, valid, last, pad, pad_len, input ready);
  modport slave  (input data_out, valid, last, pad, pad_len, output ready);
endinterface

// File: rtl/leb128_encoder.sv
// Combinational LEB128 encoder: byte i of the encoding sits in enc_bytes[8i+7:8i].
// OBU_HDR_FIXED_LEB8_EN forces an 8-byte encoding so the size can be back-patched.
module leb128_encoder
  import obu_parser_pkg::*;
(
  input  logic [55:0]                 value,
  output logic [LEB128_MAX_BYTES*8-1:0] enc_bytes,
  output logic [3:0]                  len
);

  always_comb begin
`ifdef OBU_HDR_FIXED_LEB8_EN
    len = 4'(LEB128_MAX_BYTES);
`else
    len = 4'd1;
    for (int i = 1; i < LEB128_MAX_BYTES; i++) begin
      if ((value >> (7 * i)) != 56'd0) len = 4'(i + 1);
    end
`endif
    enc_bytes = '0;
    for (int i = 0; i < LEB128_MAX_BYTES; i++) begin
      if (4'(i) < len) enc_bytes[8*i +: 8] = {(4'(i + 1) < len), value[7*i +: 7]};
    end
  end

endmodule

// File: rtl/obu_header_writer.sv
// Emits OBU header byte, optional extension byte and LEB128 obu_size as a
// packed word stream. Build option: OBU_HDR_FIXED_LEB8_EN (fixed 8-byte size).
module obu_header_writer
  import obu_parser_pkg::*;
#(
  parameter int OUT_WIDTH = PARSER_DATA_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  obu_type,
  input  logic        ext_flag,
  input  logic [2:0]  temporal_id,
  input  logic [1:0]  spatial_id,
  input  logic [55:0] obu_size,
  output logic        busy,
  output logic        done,
  obu_header_writer_if.master out_if
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiet
  // EMIT  | presenting buffered words, shifting one word per handshake
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  localparam int         HDR_BITS    = OBU_HDR_MAX_BYTES * 8;
  localparam int         MAX_WORDS   = (HDR_BITS + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int         BUF_W       = MAX_WORDS * OUT_WIDTH;
  localparam int         PW          = $clog2(OUT_WIDTH);
  localparam logic [3:0] OUT_BYTES_L = 4'(OUT_WIDTH / 8);

  obu_hdr_fields_t               fields;
  logic [LEB128_MAX_BYTES*8-1:0] leb_bytes;
  logic [3:0]                    leb_len;
  logic [HDR_BITS-1:0]           packed_hdr;
  logic [3:0]                    n_bytes;

  logic [0:0]       state;
  logic [BUF_W-1:0] word_buf;
  logic [3:0]       bytes_left;
  logic             last_w;
  logic             pad_w;
  logic [6:0]       pad_bits;

  assign fields = '{obu_type: obu_type, ext_flag: ext_flag, temporal_id: temporal_id,
                    spatial_id: spatial_id, obu_size: obu_size};

  leb128_encoder u_leb (
    .value     (fields.obu_size),
    .enc_bytes (leb_bytes),
    .len       (leb_len)
  );

  // First transmitted byte lands in the top bits of packed_hdr.
  always_comb begin
    packed_hdr = '0;
    packed_hdr[HDR_BITS-1 -: 8] = obu_hdr_byte0(fields);
    if (fields.ext_flag) packed_hdr[HDR_BITS-9 -: 8] = obu_ext_byte(fields);
    for (int j = 0; j < LEB128_MAX_BYTES; j++) begin
      packed_hdr[HDR_BITS-1-8*(1+int'(fields.ext_flag)+j) -: 8] = leb_bytes[8*j +: 8];
    end
    n_bytes = 4'd1 + {3'b000, fields.ext_flag} + leb_len;
  end

  assign busy     = (state == ST_EMIT);
  assign last_w   = busy && (bytes_left <= OUT_BYTES_L);
  assign pad_w    = last_w && (bytes_left != OUT_BYTES_L);
  assign pad_bits = {3'b000, OUT_BYTES_L - bytes_left} << 3;
  assign done     = last_w && out_if.ready;

  assign out_if.valid    = busy;
  assign out_if.data_out = busy ? word_buf[BUF_W-1 -: OUT_WIDTH] : '0;
  assign out_if.last     = last_w;
  assign out_if.pad      = pad_w;
  assign out_if.pad_len  = pad_w ? pad_bits[PW-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      word_buf   <= '0;
      bytes_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            word_buf   <= BUF_W'(packed_hdr) << (BUF_W - HDR_BITS);
            bytes_left <= n_bytes;
            state      <= ST_EMIT;
          end
        end
        default: begin
          if (out_if.ready) begin
            word_buf <= word_buf << OUT_WIDTH;
            if (last_w) begin
              bytes_left <= '0;
              state      <= ST_IDLE;
            end else begin
              bytes_left <= bytes_left - OUT_BYTES_L;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obu_header_writer.sv
// Directed table-driven bench for obu_header_writer at OUT_WIDTH=32.
module tb_obu_header_writer;
  import obu_parser_pkg::*;

  typedef struct {
    string       name;
    logic [3:0]  otype;
    logic        ext;
    logic [2:0]  tid;
    logic [1:0]  sid;
    logic [55:0] size;
    int          nwords;
    logic [95:0] words;     // first word in the top 32 bits
    int          pad_len;   // of the final word
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  obu_type = '0;
  logic        ext_flag = 1'b0;
  logic [2:0]  temporal_id = '0;
  logic [1:0]  spatial_id = '0;
  logic [55:0] obu_size = '0;
  logic        busy, done;

  int n_run = 0;
  int n_fail = 0;

  obu_header_writer_if #(.OUT_WIDTH(32)) out_if ();

  obu_header_writer #(.OUT_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .obu_type    (obu_type),
    .ext_flag    (ext_flag),
    .temporal_id (temporal_id),
    .spatial_id  (spatial_id),
    .obu_size    (obu_size),
    .busy        (busy),
    .done        (done),
    .out_if      (out_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic launch(input vec_t v);
    @(negedge clk);
    obu_type = v.otype; ext_flag = v.ext; temporal_id = v.tid;
    spatial_id = v.sid; obu_size = v.size; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    launch(v);
    for (int w = 0; w < v.nwords; w++) begin
      logic is_last;
      is_last = (w == v.nwords - 1);
      chk({v.name, " valid"}, out_if.valid, 1'b1);
      chk({v.name, " busy"}, busy, 1'b1);
      chk({v.name, " data"}, out_if.data_out, v.words[95-32*w -: 32]);
      chk({v.name, " last"}, out_if.last, is_last);
      chk({v.name, " pad"}, out_if.pad, is_last && (v.pad_len != 0));
      chk({v.name, " pad_len"}, out_if.pad_len, is_last ? v.pad_len : 0);
      chk({v.name, " done"}, done, is_last);
      @(negedge clk);
    end
    chk({v.name, " valid after"}, out_if.valid, 1'b0);
    chk({v.name, " busy after"}, busy, 1'b0);
  endtask

  vec_t vecs[$];
  vec_t vmax, vbp;
  logic [31:0] bp_word;
  logic        bp_last;

  initial begin
    vmax = '{"max", 4'd2, 1'b0, 3'd0, 2'd0, 56'hFF_FFFF_FFFF_FFFF, 3,
             96'h12FFFFFF_FFFFFFFF_7F000000, 24};
    vbp  = '{"bp300", 4'd6, 1'b1, 3'd2, 2'd1, 56'd300, 1, 96'h0, 0};
`ifdef OBU_HDR_FIXED_LEB8_EN
    vecs.push_back('{"fx_t1_s10", 4'd1, 1'b0, 3'd0, 2'd0, 56'd10, 3,
                     96'h0A8A8080_80808080_00000000, 24});
    vecs.push_back('{"fx_ext_s0", 4'd6, 1'b1, 3'd2, 2'd1, 56'd0, 3,
                     96'h36488080_80808080_80000000, 16});
    vecs.push_back(vmax);
    bp_word = 32'h3648AC82; bp_last = 1'b0;
`else
    vecs.push_back('{"t1_s10", 4'd1, 1'b0, 3'd0, 2'd0, 56'd10, 1,
                     96'h0A0A0000_00000000_00000000, 16});
    vecs.push_back('{"t6_ext_s300", 4'd6, 1'b1, 3'd2, 2'd1, 56'd300, 1,
                     96'h3648AC02_00000000_00000000, 0});
    vecs.push_back(vmax);
    vecs.push_back('{"pad_s0", 4'd15, 1'b0, 3'd0, 2'd0, 56'd0, 1,
                     96'h7A000000_00000000_00000000, 16});
    vecs.push_back('{"s127", 4'd3, 1'b0, 3'd0, 2'd0, 56'd127, 1,
                     96'h1A7F0000_00000000_00000000, 16});
    vecs.push_back('{"ext_s128", 4'd4, 1'b1, 3'd7, 2'd3, 56'd128, 1,
                     96'h26F88001_00000000_00000000, 0});
    vecs.push_back('{"s16384", 4'd5, 1'b0, 3'd0, 2'd0, 56'd16384, 1,
                     96'h2A808001_00000000_00000000, 0});
    vecs.push_back('{"ext_s2p21", 4'd5, 1'b1, 3'd0, 2'd0, 56'd2097152, 2,
                     96'h2E008080_80010000_00000000, 16});
    bp_word = 32'h3648AC02; bp_last = 1'b1;
`endif

    out_if.ready = 1'b1;
    #2;
    chk("rst busy", busy, 1'b0);
    chk("rst valid", out_if.valid, 1'b0);
    chk("rst last", out_if.last, 1'b0);
    chk("rst pad", out_if.pad, 1'b0);
    chk("rst pad_len", out_if.pad_len, 0);
    chk("rst done", done, 1'b0);
    chk("rst data", out_if.data_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: word and flags held, done only with the handshake.
    out_if.ready = 1'b0;
    launch(vbp);
    for (int c = 0; c < 5; c++) begin
      chk("bp valid", out_if.valid, 1'b1);
      chk("bp data", out_if.data_out, bp_word);
      chk("bp last", out_if.last, bp_last);
      chk("bp done", done, 1'b0);
      @(negedge clk);
    end
    out_if.ready = 1'b1;
    #1;
    chk("bp done on ready", done, bp_last);
    for (int c = 0; c < 4 && out_if.valid; c++) @(negedge clk);
    chk("bp drained", out_if.valid, 1'b0);

    // start during EMIT and during the final handshake is ignored.
    launch(vmax);
    for (int w = 0; w < 3; w++) begin
      chk("ign data", out_if.data_out, vmax.words[95-32*w -: 32]);
      chk("ign last", out_if.last, w == 2);
      if (w == 0) begin
        obu_type = 4'd1; ext_flag = 1'b1; obu_size = 56'd10; start = 1'b1;
      end else if (w == 1) begin
        start = 1'b0;
      end else begin
        start = 1'b1;
      end
      @(negedge clk);
    end
    chk("ign final start", out_if.valid, 1'b0);
    start = 1'b0;
    @(negedge clk);
    chk("ign still idle", busy, 1'b0);

    // Asynchronous reset after the first word discards the header.
    launch(vmax);
    @(negedge clk);
    chk("mid word1", out_if.data_out, 32'hFFFFFFFF);
    rst_n = 1'b0;
    #1;
    chk("arst valid", out_if.valid, 1'b0);
    chk("arst busy", busy, 1'b0);
    chk("arst data", out_if.data_out, 0);
    chk("arst last", out_if.last, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/obu_header_writer.md
Name: obu_header_writer

Overview:
- Emits an AV1 OBU header into the byte-packed word stream consumed by the parser side: the header byte, an optional extension byte, and obu_size as LEB128.
- Used by the stream writer and by loopback verification of the parser chain.
- Fields are latched on `start`. Output words leave MSB-first over a valid/ready handshake.
- Partial final word is flagged with `pad`/`pad_len`, matching the parser-side convention.

Parameters:
- OUT_WIDTH, default PARSER_DATA_WIDTH (32): output word width. Multiple of 8, range 16..64.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; accepted only when busy=0
- obu_type  in  4  OBU type field
- ext_flag  in  1  emit extension byte
- temporal_id  in  3  extension temporal_id
- spatial_id  in  2  extension spatial_id
- obu_size  in  56  payload size in bytes
- busy  out  1  header being emitted
- data_out  out  OUT_WIDTH  output word; first byte in the top bits
- valid  out  1  data_out valid
- ready  in  1  downstream accepts the word
- last  out  1  current word is the final header word
- pad  out  1  final word only partially filled
- pad_len  out  $clog2(OUT_WIDTH)  unused bit count of the final word
- done  out  1  one-cycle pulse on the final handshake

Behaviour:
- Reset: busy, valid, last, pad, done = 0; pad_len = 0; data_out = 0; state IDLE.
- Byte 0: {1'b0, obu_type, ext_flag, 1'b1 (has_size_field), 1'b0}.
- Extension byte, present only when ext_flag=1: {temporal_id, spatial_id, 3'b000}.
- LEB128 encoding:
  - Minimal length 1..8 bytes, least-significant 7-bit group first.
  - bit7 = 1 on every byte except the last.
  - obu_size = 0 encodes as a single 0x00 byte.
- Total length N = 1 + ext_flag + leb_len, i.e. 2..10 bytes. Word count = ceil(N*8/OUT_WIDTH).
- State machine, IDLE -> EMIT -> IDLE:
  - IDLE: start=1 latches a byte buffer of up to 10 bytes plus N, then moves to EMIT. valid rises the cycle after start (latency 1).
  - EMIT: valid=1. On valid&&ready the buffer shifts by one word.
  - On the final handshake: done=1 for that same cycle (combinational with the handshake), then next state is IDLE with valid=0.
  - busy = (state==EMIT).
- While valid=1 and ready=0, data_out, last, pad and pad_len are held stable.
- Unused byte lanes in the final word are zero.
- last=1 only on the final word. On that word:
  - pad = (N*8 mod OUT_WIDTH != 0)
  - pad_len = OUT_WIDTH - 8*(bytes in final word) when pad=1, otherwise 0.
  - On non-final words, pad=0 and pad_len=0.
- start while busy=1 is ignored; the latched fields are unchanged.
- start in the same cycle as the final handshake is also ignored. A new start is accepted from the next cycle.
- rst_n low at any time: all outputs return to their reset values immediately (asynchronous) and the in-flight header is discarded.

Optional Feature:
- Macro: OBU_HDR_FIXED_LEB8_EN
- Defined: obu_size is always encoded in 8 LEB128 bytes (the first 7 have bit7=1, non-minimal but legal), so N = 9 + ext_flag. This allows later back-patching of the size field.
- Undefined: minimal-length encoding.

Decomposition:
- obu_parser_pkg gains:
  - LEB128_MAX_BYTES = 8
  - OBU_HDR_MAX_BYTES = 10
  - an obu_type_e enum (SEQUENCE_HEADER=1, TEMPORAL_DELIMITER=2, FRAME_HEADER=3, TILE_GROUP=4, METADATA=5, FRAME=6, PADDING=15)
  - an obu_hdr_fields_t struct holding the input fields
- Sub-module leb128_encoder, the inverse of leb128_parser: combinational 56-bit -> 64-bit byte vector plus a 4-bit length. OBU_HDR_FIXED_LEB8_EN is applied inside it.

Test Plan (OUT_WIDTH=32):
- type=1, ext=0, size=10 -> one word 0x0A0A0000; last=1, pad=1, pad_len=16; done pulses with the handshake.
- type=6, ext=1, tid=2, sid=1, size=300 -> one word 0x3648AC02; last=1, pad=0, pad_len=0.
- type=2, ext=0, size=2^56-1 -> three words:
  - 0x12FFFFFF
  - 0xFFFFFFFF
  - 0x7F000000 with last=1, pad_len=24
- Backpressure: size=300 case with ready=0 for 5 cycles -> valid stays high, data_out is stable, done=0; done pulses exactly on the cycle ready rises.
- start pulsed during EMIT with different fields -> output unchanged. rst_n asserted after the first word -> valid=0 and busy=0 immediately; a fresh start then emits correctly.
- With OBU_HDR_FIXED_LEB8_EN, type=1, size=10 -> three words:
  - 0x0A8A8080
  - 0x80808080
  - 0x00000000 with last=1, pad_len=24
